// File: rtl/ps2_joy_pkg.sv
// Shared button layout, frame FSM states and scancode-to-joystick map.
// Pure declarations: no latency, no backpressure.
package ps2_joy_pkg;

   localparam int BTN_R     = 0;
   localparam int BTN_L     = 1;
   localparam int BTN_D     = 2;
   localparam int BTN_U     = 3;
   localparam int BTN_B1    = 4;
   localparam int BTN_START = 5;
   localparam int BTN_B2    = 6;
   localparam int BTN_COIN  = 7;
   localparam int BTN_B3    = 8;
   localparam int BTN_B4    = 9;

   localparam logic [7:0] CODE_EXT   = 8'hE0;
   localparam logic [7:0] CODE_BRK   = 8'hF0;
   localparam logic [7:0] CODE_PAUSE = 8'hE1;
   localparam logic [7:0] CODE_BAT   = 8'hAA;
   localparam logic [7:0] CODE_OVR0  = 8'h00;
   localparam logic [7:0] CODE_OVR1  = 8'hFF;
   localparam int         PAUSE_SKIP = 7;

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_t;

   typedef struct packed {
      logic       hit;
      logic [1:0] player;
      logic [3:0] btn;
   } key_map_t;

   function automatic key_map_t km_entry(input int p, input int b);
      key_map_t e;
      e.hit    = 1'b1;
      e.player = 2'(p);
      e.btn    = 4'(b);
      return e;
   endfunction

   // Arrows need the E0 prefix; the same codes without it are the P2 keypad.
   function automatic key_map_t map_key(input logic ext, input logic [7:0] code);
      key_map_t m;
      m = '0;
      case ({ext, code})
         9'h174: m = km_entry(0, BTN_R);
         9'h16B: m = km_entry(0, BTN_L);
         9'h172: m = km_entry(0, BTN_D);
         9'h175: m = km_entry(0, BTN_U);
         9'h029: m = km_entry(0, BTN_B1);
         9'h005: m = km_entry(0, BTN_START);
         9'h014: m = km_entry(0, BTN_B2);
         9'h076: m = km_entry(0, BTN_COIN);
         9'h011: m = km_entry(0, BTN_B3);
         9'h012: m = km_entry(0, BTN_B4);
         9'h023: m = km_entry(1, BTN_R);
         9'h01C: m = km_entry(1, BTN_L);
         9'h01B: m = km_entry(1, BTN_D);
         9'h01D: m = km_entry(1, BTN_U);
         9'h02B: m = km_entry(1, BTN_B1);
         9'h006: m = km_entry(1, BTN_START);
         9'h034: m = km_entry(1, BTN_B2);
         9'h016: m = km_entry(1, BTN_COIN);
         9'h033: m = km_entry(1, BTN_B3);
         9'h03B: m = km_entry(1, BTN_B4);
         9'h074: m = km_entry(2, BTN_R);
         9'h06B: m = km_entry(2, BTN_L);
         9'h072: m = km_entry(2, BTN_D);
         9'h075: m = km_entry(2, BTN_U);
         9'h070: m = km_entry(2, BTN_B1);
         9'h004: m = km_entry(2, BTN_START);
         9'h071: m = km_entry(2, BTN_B2);
         9'h079: m = km_entry(2, BTN_COIN);
         9'h07B: m = km_entry(2, BTN_B3);
         9'h07C: m = km_entry(2, BTN_B4);
         9'h07A: m = km_entry(3, BTN_R);
         9'h069: m = km_entry(3, BTN_L);
         9'h073: m = km_entry(3, BTN_D);
         9'h07D: m = km_entry(3, BTN_U);
         9'h06C: m = km_entry(3, BTN_B1);
         9'h00C: m = km_entry(3, BTN_START);
         9'h077: m = km_entry(3, BTN_COIN);
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 line sync/filter plus frame FSM; byte_valid/rx_error are combinational in the stop-bit sample cycle.
// No backpressure: the keyboard cannot be stalled, every byte is presented exactly once.
module ps2_rx_frame
   import ps2_joy_pkg::*;
#(
   parameter int CLK_HZ     = 48_384_000,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT_US = 2000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       rx_error
);
   localparam longint TO_CYC = (longint'(CLK_HZ) * longint'(TIMEOUT_US)) / 64'd1_000_000;
   localparam int     TO_W   = $clog2(TO_CYC + 1);
   localparam int     FL_W   = $clog2(FILTER_LEN + 1);

   // Index 0 is the clock line, index 1 the data line.
   logic [1:0]      sync1, line_s, line_f, flip;
   logic [FL_W-1:0] fcnt [2];
   logic            sample, bit_in, timeout;
   rx_state_t       state, state_n;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            par_bit;
   logic [TO_W-1:0] to_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1   <= 2'b11;
         line_s  <= 2'b11;
         line_f  <= 2'b11;
         fcnt[0] <= '0;
         fcnt[1] <= '0;
      end else begin
         sync1  <= {ps2_dat, ps2_clk};
         line_s <= sync1;
         for (int i = 0; i < 2; i++) begin
            if (line_s[i] == line_f[i]) begin
               fcnt[i] <= '0;
            end else if (flip[i]) begin
               line_f[i] <= line_s[i];
               fcnt[i]   <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      flip = '0;
      for (int i = 0; i < 2; i++)
         flip[i] = (line_s[i] != line_f[i]) && (fcnt[i] == FL_W'(FILTER_LEN - 1));
   end

   assign sample  = flip[0] && line_f[0];
   assign bit_in  = line_f[1];
   assign timeout = (state != ST_IDLE) && !sample && (to_cnt == TO_W'(TO_CYC - 1));
   assign rx_byte = shreg;

   always_comb begin
      state_n    = state;
      byte_valid = 1'b0;
      rx_error   = 1'b0;
      if (timeout) begin
         state_n  = ST_IDLE;
         rx_error = 1'b1;
      end else if (sample) begin
         case (state)
            ST_IDLE:   if (!bit_in) state_n = ST_DATA;
                       else rx_error = 1'b1;
            ST_DATA:   if (bit_cnt == 3'd7) state_n = ST_PARITY;
            ST_PARITY: state_n = ST_STOP;
            ST_STOP: begin
               state_n = ST_IDLE;
               if (bit_in && (^{shreg, par_bit})) byte_valid = 1'b1;
               else rx_error = 1'b1;
            end
            default:   state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         to_cnt  <= '0;
      end else begin
         state <= state_n;
         if (sample || state == ST_IDLE) to_cnt <= '0;
         else to_cnt <= to_cnt + 1'b1;
         if (sample) begin
            case (state)
               ST_IDLE:   bit_cnt <= '0;
               ST_DATA: begin
                  shreg   <= {bit_in, shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
               ST_PARITY: par_bit <= bit_in;
               default:   ;
            endcase
         end
      end
   end

endmodule

// File: rtl/ps2_joystick_mapper.sv
// PS/2 keyboard to per-player joystick vectors with prefix decode and autofire.
// key_strobe 1 clk and joystick 2 clk after the stop-bit sample; no backpressure.
module ps2_joystick_mapper
   import ps2_joy_pkg::*;
#(
   parameter int CLK_HZ      = 48_384_000,
   parameter int NUM_PLAYERS = 2,
   parameter int BUTTONS     = 10,
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_US  = 2000,
   parameter int AUTOFIRE_HZ = 10
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           ps2_clk,
   input  logic                           ps2_dat,
   input  logic [NUM_PLAYERS-1:0]         autofire_en,
   output logic [NUM_PLAYERS*BUTTONS-1:0] joystick,
   output logic                           key_strobe,
   output logic [7:0]                     scancode,
   output logic                           key_extended,
   output logic                           key_released,
   output logic                           rx_error
);
   localparam int AF_HALF = CLK_HZ / (2 * AUTOFIRE_HZ);
   localparam int AF_W    = $clog2(AF_HALF + 1);

   logic [7:0]                         rx_byte;
   logic                               byte_valid, rx_err;
   logic                               ext_f, brk_f;
   logic [2:0]                         skip_cnt;
   key_map_t                           km;
   logic [NUM_PLAYERS-1:0][BUTTONS-1:0] held, js_next;
   logic [AF_W-1:0]                    af_cnt;
   logic                               af_phase;

   ps2_rx_frame #(
      .CLK_HZ     (CLK_HZ),
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT_US (TIMEOUT_US)
   ) u_rx (
      .clk        (clk),
      .reset_n    (reset_n),
      .ps2_clk    (ps2_clk),
      .ps2_dat    (ps2_dat),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .rx_error   (rx_err)
   );

   assign km = map_key(ext_f, rx_byte);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         held         <= '0;
         ext_f        <= 1'b0;
         brk_f        <= 1'b0;
         skip_cnt     <= '0;
         key_strobe   <= 1'b0;
         scancode     <= '0;
         key_extended <= 1'b0;
         key_released <= 1'b0;
         rx_error     <= 1'b0;
      end else begin
         key_strobe <= 1'b0;
         rx_error   <= rx_err;
         if (rx_err) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
         end else if (byte_valid) begin
            // The Pause sequence tail must not be decoded as ordinary keys.
            if (skip_cnt != 3'd0) begin
               skip_cnt <= skip_cnt - 3'd1;
            end else begin
               case (rx_byte)
                  CODE_EXT:   ext_f    <= 1'b1;
                  CODE_BRK:   brk_f    <= 1'b1;
                  CODE_PAUSE: skip_cnt <= 3'(PAUSE_SKIP);
                  CODE_BAT, CODE_OVR0, CODE_OVR1: begin
                     held  <= '0;
                     ext_f <= 1'b0;
                     brk_f <= 1'b0;
                  end
                  default: begin
                     key_strobe   <= 1'b1;
                     scancode     <= rx_byte;
                     key_extended <= ext_f;
                     key_released <= brk_f;
                     ext_f        <= 1'b0;
                     brk_f        <= 1'b0;
                     for (int p = 0; p < NUM_PLAYERS; p++)
                        for (int b = 0; b < BUTTONS; b++)
                           if (km.hit && km.player == 2'(p) && km.btn == 4'(b))
                              held[p][b] <= ~brk_f;
                  end
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         af_cnt   <= '0;
         af_phase <= 1'b1;
      end else if (af_cnt == AF_W'(AF_HALF - 1)) begin
         af_cnt   <= '0;
         af_phase <= ~af_phase;
      end else begin
         af_cnt <= af_cnt + 1'b1;
      end
   end

   always_comb begin
      js_next = held;
      for (int p = 0; p < NUM_PLAYERS; p++)
         if (autofire_en[p]) js_next[p][BTN_B1] = held[p][BTN_B1] & af_phase;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) joystick <= '0;
      else joystick <= js_next;
   end

endmodule

// File: tb/tb_ps2_joystick_mapper.sv
// Directed bench for ps2_joystick_mapper with scaled-down clock, timeout and autofire rates.
// Bit-banged PS/2 frames; a negedge monitor records strobes, errors and joystick around each strobe.
module tb_ps2_joystick_mapper;
   localparam int CLK_HZ      = 1_000_000;
   localparam int NUM_PLAYERS = 2;
   localparam int BUTTONS     = 10;
   localparam int FILTER_LEN  = 4;
   localparam int TIMEOUT_US  = 200;
   localparam int AUTOFIRE_HZ = 2500;
   localparam int TO_CYC      = 200;
   localparam int AF_HALF     = 200;
   localparam int JW          = NUM_PLAYERS * BUTTONS;

   logic                   clk = 1'b0;
   logic                   reset_n;
   logic                   ps2_clk, ps2_dat;
   logic [NUM_PLAYERS-1:0] autofire_en;
   logic [JW-1:0]          joystick;
   logic                   key_strobe, key_extended, key_released, rx_error;
   logic [7:0]             scancode;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int stop_fall_cyc = 0;
   int strobe_cnt = 0, err_cnt = 0, strobe_cyc = 0;
   logic [7:0]    last_code;
   logic          last_ext, last_rel, cap_next = 1'b0;
   logic [JW-1:0] js_at_strobe, js_after;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   ps2_joystick_mapper #(
      .CLK_HZ(CLK_HZ), .NUM_PLAYERS(NUM_PLAYERS), .BUTTONS(BUTTONS),
      .FILTER_LEN(FILTER_LEN), .TIMEOUT_US(TIMEOUT_US), .AUTOFIRE_HZ(AUTOFIRE_HZ)
   ) dut (
      .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
      .autofire_en(autofire_en), .joystick(joystick), .key_strobe(key_strobe),
      .scancode(scancode), .key_extended(key_extended), .key_released(key_released),
      .rx_error(rx_error)
   );

   always @(negedge clk) begin
      if (cap_next) begin
         js_after = joystick;
         cap_next = 1'b0;
      end
      if (key_strobe) begin
         strobe_cnt++;
         strobe_cyc   = cyc;
         last_code    = scancode;
         last_ext     = key_extended;
         last_rel     = key_released;
         js_at_strobe = joystick;
         cap_next     = 1'b1;
      end
      if (rx_error) err_cnt++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ps2_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         wait_clk(10);
         ps2_dat = bits[i];
         wait_clk(10);
         ps2_clk = 1'b0;
         if (i == 10) stop_fall_cyc = cyc;
         wait_clk(20);
         ps2_clk = 1'b1;
      end
      wait_clk(20);
      ps2_dat = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad_par);
      ps2_bits({1'b1, (~^b) ^ bad_par, b, 1'b0}, 11);
   endtask

   task automatic test_reset;
      reset_n = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1; autofire_en = '0;
      wait_clk(5);
      checks++;
      if (joystick !== '0) begin errors++; $display("FAIL reset_joystick got=%h want=0", joystick); end
      checks++;
      if ({key_strobe, scancode, key_extended, key_released, rx_error} !== 12'h0) begin
         errors++;
         $display("FAIL reset_outputs got strobe=%b code=%h ext=%b rel=%b err=%b want all 0",
                  key_strobe, scancode, key_extended, key_released, rx_error);
      end
      reset_n = 1'b1;
      wait_clk(20);
   endtask

   task automatic test_space;
      int s0;
      s0 = strobe_cnt;
      send_byte(8'h29, 1'b0);
      checks++;
      if (strobe_cnt != s0 + 1 || last_code !== 8'h29 || last_ext !== 1'b0 || last_rel !== 1'b0) begin
         errors++;
         $display("FAIL space_make_strobe got n=%0d code=%h ext=%b rel=%b want n=1 code=29 ext=0 rel=0",
                  strobe_cnt - s0, last_code, last_ext, last_rel);
      end
      checks++;
      if (js_at_strobe[4] !== 1'b0 || js_after[4] !== 1'b1) begin
         errors++;
         $display("FAIL space_make_latency got at_strobe=%b after=%b want 0 then 1", js_at_strobe[4], js_after[4]);
      end
      checks++;
      if (strobe_cyc - stop_fall_cyc < FILTER_LEN + 1 || strobe_cyc - stop_fall_cyc > FILTER_LEN + 4) begin
         errors++;
         $display("FAIL space_strobe_delay got=%0d want %0d..%0d", strobe_cyc - stop_fall_cyc,
                  FILTER_LEN + 1, FILTER_LEN + 4);
      end
      send_byte(8'hF0, 1'b0);
      send_byte(8'h29, 1'b0);
      checks++;
      if (last_rel !== 1'b1 || joystick !== '0) begin
         errors++;
         $display("FAIL space_break got rel=%b js=%h want rel=1 js=0", last_rel, joystick);
      end
   endtask

   task automatic test_extended;
      send_byte(8'hE0, 1'b0);
      send_byte(8'h75, 1'b0);
      checks++;
      if (last_code !== 8'h75 || last_ext !== 1'b1 || joystick !== 20'h00008) begin
         errors++;
         $display("FAIL ext_up got code=%h ext=%b js=%h want code=75 ext=1 js=00008", last_code, last_ext, joystick);
      end
      send_byte(8'h75, 1'b0);
      checks++;
      if (last_ext !== 1'b0 || joystick !== 20'h00008) begin
         errors++;
         $display("FAIL plain_75_unmapped got ext=%b js=%h want ext=0 js=00008", last_ext, joystick);
      end
      send_byte(8'hE0, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h75, 1'b0);
      checks++;
      if (joystick !== '0 || last_ext !== 1'b1 || last_rel !== 1'b1) begin
         errors++;
         $display("FAIL ext_up_break got js=%h ext=%b rel=%b want js=0 ext=1 rel=1", joystick, last_ext, last_rel);
      end
   endtask

   task automatic test_pause;
      int s0;
      logic [7:0] seq [8];
      seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      s0 = strobe_cnt;
      for (int i = 0; i < 8; i++) send_byte(seq[i], 1'b0);
      checks++;
      if (strobe_cnt != s0 || joystick !== '0) begin
         errors++;
         $display("FAIL pause_skip got strobes=%0d js=%h want 0 strobes js=0", strobe_cnt - s0, joystick);
      end
      send_byte(8'h12, 1'b0);
      checks++;
      if (strobe_cnt != s0 + 1 || joystick !== 20'h00200) begin
         errors++;
         $display("FAIL after_pause_b4 got strobes=%0d js=%h want 1 strobe js=00200", strobe_cnt - s0, joystick);
      end
      send_byte(8'hF0, 1'b0);
      send_byte(8'h12, 1'b0);
   endtask

   task automatic test_parity_error;
      int s0, e0;
      s0 = strobe_cnt; e0 = err_cnt;
      send_byte(8'h29, 1'b1);
      checks++;
      if (err_cnt != e0 + 1 || strobe_cnt != s0 || joystick !== '0) begin
         errors++;
         $display("FAIL parity_error got errs=%0d strobes=%0d js=%h want 1 err 0 strobes js=0",
                  err_cnt - e0, strobe_cnt - s0, joystick);
      end
      send_byte(8'h14, 1'b0);
      checks++;
      if (joystick !== 20'h00040 || last_code !== 8'h14) begin
         errors++;
         $display("FAIL parity_recover got js=%h code=%h want js=00040 code=14", joystick, last_code);
      end
      send_byte(8'hF0, 1'b0);
      send_byte(8'h14, 1'b0);
   endtask

   task automatic test_timeout;
      int s0, e0;
      s0 = strobe_cnt; e0 = err_cnt;
      ps2_bits({1'b1, 1'b0, 8'h1D, 1'b0}, 5);
      wait_clk(TO_CYC + 60);
      checks++;
      if (err_cnt != e0 + 1 || strobe_cnt != s0) begin
         errors++;
         $display("FAIL timeout_error got errs=%0d strobes=%0d want 1 err 0 strobes", err_cnt - e0, strobe_cnt - s0);
      end
      send_byte(8'h1D, 1'b0);
      checks++;
      if (joystick !== 20'h02000 || last_code !== 8'h1D) begin
         errors++;
         $display("FAIL timeout_recover got js=%h code=%h want js=02000 code=1D", joystick, last_code);
      end
   endtask

   task automatic test_autofire;
      int ntr, bad_int, p1_bad, last_t;
      logic prev;
      autofire_en = 2'b01;
      send_byte(8'h29, 1'b0);
      send_byte(8'h2B, 1'b0);
      ntr = 0; bad_int = 0; p1_bad = 0; last_t = -1;
      @(negedge clk);
      prev = joystick[4];
      for (int i = 0; i < 3 * AF_HALF + 10; i++) begin
         @(negedge clk);
         if (joystick[14] !== 1'b1 || joystick[13] !== 1'b1) p1_bad++;
         if (joystick[4] !== prev) begin
            if (last_t >= 0 && cyc - last_t != AF_HALF) bad_int++;
            last_t = cyc;
            ntr++;
            prev = joystick[4];
         end
      end
      checks++;
      if (ntr < 3 || bad_int != 0) begin
         errors++;
         $display("FAIL autofire_toggle got toggles=%0d bad_intervals=%0d want >=3 toggles 0 bad", ntr, bad_int);
      end
      checks++;
      if (p1_bad != 0) begin
         errors++;
         $display("FAIL autofire_p1_static got bad_cycles=%0d want 0", p1_bad);
      end
      autofire_en = 2'b00;
      wait_clk(4);
      checks++;
      if (joystick[4] !== 1'b1) begin
         errors++;
         $display("FAIL autofire_off got js4=%b want 1", joystick[4]);
      end
   endtask

   task automatic test_bat;
      int s0;
      send_byte(8'h76, 1'b0);
      checks++;
      if ((joystick & 20'h02080) !== 20'h02080) begin
         errors++;
         $display("FAIL bat_pre_hold got js=%h want bits 7 and 13 set", joystick);
      end
      s0 = strobe_cnt;
      send_byte(8'hAA, 1'b0);
      checks++;
      if (joystick !== '0 || strobe_cnt != s0) begin
         errors++;
         $display("FAIL bat_clear got js=%h strobes=%0d want js=0 0 strobes", joystick, strobe_cnt - s0);
      end
   endtask

   task automatic test_reset_midframe;
      ps2_bits({1'b1, 1'b0, 8'h23, 1'b0}, 4);
      reset_n = 1'b0;
      wait_clk(3);
      checks++;
      if (joystick !== '0 || {key_strobe, scancode, key_extended, key_released, rx_error} !== 12'h0) begin
         errors++;
         $display("FAIL midframe_reset got js=%h code=%h ext=%b rel=%b want all 0",
                  joystick, scancode, key_extended, key_released);
      end
      reset_n = 1'b1;
      wait_clk(20);
      send_byte(8'h1C, 1'b0);
      checks++;
      if (joystick !== 20'h00800 || last_code !== 8'h1C || last_ext !== 1'b0 || last_rel !== 1'b0) begin
         errors++;
         $display("FAIL midframe_recover got js=%h code=%h ext=%b rel=%b want js=00800 code=1C ext=0 rel=0",
                  joystick, last_code, last_ext, last_rel);
      end
   endtask

   initial begin
      test_reset();
      test_space();
      test_extended();
      test_pause();
      test_parity_error();
      test_timeout();
      test_autofire();
      test_bat();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
